johnson_decoder: RTL

- Receiving end of the Johnson counter: samples an N-bit Johnson code word each valid cycle and decodes it to a binary phase index.
- Rejects illegal (non-Johnson) patterns.
- Tracks the expected successor to detect skipped or backward steps.
- Runs a lock FSM and keeps a saturating error count for the monitoring logic downstream of the counter.

---
 rtl/johnson_decoder_if.sv | 28 ++
 rtl/johnson_decoder.sv | 111 +++++++++++
 2 files changed

// File: rtl/johnson_decoder_if.sv
// Bus between a Johnson counter tap and its decoder: sampled code word in,
// decoded phase index plus lock/error status out.
interface johnson_decoder_if #(
    parameter int N  = 4,
    parameter int CW = 8
) ();
    localparam int IW = $clog2(2 * N);

    logic [N-1:0]  jc_in;
    logic          jc_valid;
    logic          err_clr;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [CW-1:0] err_cnt;

    modport master (
        output jc_in, jc_valid, err_clr,
        input  idx, idx_valid, illegal, seq_err, locked, err_cnt
    );

    modport slave (
        input  jc_in, jc_valid, err_clr,
        output idx, idx_valid, illegal, seq_err, locked, err_cnt
    );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson code decoder: two-stage pipeline that decodes a code word to a phase
// index, flags illegal words and sequence errors, and tracks lock.
//
// state  | meaning
// SEARCH | waiting for any legal word
// CHECK  | one legal word seen, waiting for its successor
// LOCKED | sequence verified; errors are counted here
module johnson_decoder #(
    parameter int N          = 4,
    parameter bit ALLOW_HOLD = 1'b1,
    parameter int CW         = 8
) (
    input logic               clk,
    input logic               rst_n,
    johnson_decoder_if.slave  bus
);
    localparam int IW = $clog2(2 * N);
    localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t        state_q;
    logic [N-1:0]  code_q;
    logic          valid_q;
    logic [IW-1:0] idx_q;
    logic          idx_valid_q;
    logic          illegal_q;
    logic          seq_err_q;
    logic [CW-1:0] err_cnt_q;

    logic          legal_d;
    logic [IW-1:0] dec_idx_d;
    logic [IW-1:0] exp_idx_d;
    logic          is_exp_d;
    logic          is_hold_d;
    logic          err_inc_d;
    logic [N-1:0]  mask_d;
    int            pc_d;

    // A legal word is a run of ones anchored at bit 0 (MSB clear) or at the MSB.
    always_comb begin
        pc_d = 0;
        for (int i = 0; i < N; i++) begin
            if (code_q[i]) pc_d++;
        end
        if (!code_q[N-1]) begin
            mask_d    = N'((32'd1 << pc_d) - 32'd1);
            dec_idx_d = IW'(pc_d);
        end else begin
            mask_d    = {N{1'b1}} << (N - pc_d);
            dec_idx_d = IW'(2 * N - pc_d);
        end
        legal_d   = (code_q == mask_d);
        exp_idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        is_exp_d  = (dec_idx_d == exp_idx_d);
        is_hold_d = ALLOW_HOLD && (dec_idx_d == idx_q);
        err_inc_d = valid_q && (state_q == LOCKED) &&
                    !(legal_d && (is_exp_d || is_hold_d));
    end

    // idx_q only moves on legal words, so it doubles as the last legal index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            code_q      <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            code_q      <= bus.jc_in;
            valid_q     <= bus.jc_valid;
            idx_valid_q <= valid_q;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            if (valid_q) begin
                illegal_q <= !legal_d;
                if (legal_d) idx_q <= dec_idx_d;
                case (state_q)
                    SEARCH: if (legal_d) state_q <= CHECK;
                    CHECK: begin
                        if (!legal_d)      state_q <= SEARCH;
                        else if (is_exp_d) state_q <= LOCKED;
                    end
                    LOCKED: begin
                        if (!legal_d) begin
                            state_q <= SEARCH;
                        end else if (!(is_exp_d || is_hold_d)) begin
                            seq_err_q <= 1'b1;
                            state_q   <= CHECK;
                        end
                    end
                    default: state_q <= SEARCH;
                endcase
            end
            if (bus.err_clr)
                err_cnt_q <= '0;
            else if (err_inc_d && (err_cnt_q != {CW{1'b1}}))
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = idx_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_cnt   = err_cnt_q;
endmodule
